// File: rtl/pcie_app_rst_seq_if.sv
// rtl/pcie_app_rst_seq_if.sv - signal bundle between the reset sequencer and the TLP application
interface pcie_app_rst_seq_if;
    logic [4:0] ltssm;
    logic       sw_rst_req;
    logic       quiesce_ack;
    logic       quiesce_req;
    logic       tx_rstn;
    logic       rx_rstn;
    logic       core_rstn;
    logic       seq_busy;
    logic       seq_done;
    logic       qto_flag;

    modport master (
        input  ltssm, sw_rst_req, quiesce_ack,
        output quiesce_req, tx_rstn, rx_rstn, core_rstn, seq_busy, seq_done, qto_flag
    );

    modport slave (
        output ltssm, sw_rst_req, quiesce_ack,
        input  quiesce_req, tx_rstn, rx_rstn, core_rstn, seq_busy, seq_done, qto_flag
    );
endinterface

// File: rtl/pcie_app_rst_seq.sv
// rtl/pcie_app_rst_seq.sv - quiesce-then-sequence TX/RX/core application resets from HIP and software events
module pcie_app_rst_seq #(
    parameter int HOLD_CYC = 16,
    parameter int GAP_CYC  = 4,
    parameter int QTO_CYC  = 1024,
    parameter int LDN_DEB  = 8,
    parameter int CNT_W    = 11
) (
    input  logic               pld_clk,
    input  logic               app_rstn,
    pcie_app_rst_seq_if.master bus
);
    localparam logic [4:0]       LT_L0  = 5'h0F;
    localparam logic [4:0]       LT_HOT = 5'h10;
    localparam logic [CNT_W-1:0] GAP1   = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] GAP2   = CNT_W'(2 * GAP_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD1  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] QTO1   = CNT_W'(QTO_CYC - 1);
    localparam int               LDN_W  = $clog2(LDN_DEB + 1);
    localparam logic [LDN_W-1:0] LDN1   = LDN_W'(LDN_DEB - 1);

    typedef enum logic [2:0] {S_IDLE, S_QUIESCE, S_ASSERT, S_HOLD, S_RELEASE} state_t;

    logic             is_l0, is_hot;
    logic             l0_seen, hot_prev, ldn_evt, hot_evt;
    logic [LDN_W-1:0] ldn_cnt;
    logic             req;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             pend;
    logic             quiesce_req, tx_rstn, rx_rstn, core_rstn, seq_busy, seq_done, qto_flag;

    assign is_l0  = (bus.ltssm == LT_L0);
    assign is_hot = (bus.ltssm == LT_HOT);
    assign req    = bus.sw_rst_req | ldn_evt | hot_evt;

    // Link-down only counts once L0 has been reached, so training before first L0 is not an event.
    always_ff @(posedge pld_clk) begin
        if (!app_rstn) begin
            l0_seen  <= 1'b0;
            ldn_cnt  <= '0;
            ldn_evt  <= 1'b0;
            hot_prev <= 1'b0;
            hot_evt  <= 1'b0;
        end else begin
            hot_prev <= is_hot;
            hot_evt  <= is_hot & ~hot_prev;
            ldn_evt  <= 1'b0;
            if (is_l0) begin
                l0_seen <= 1'b1;
                ldn_cnt <= '0;
            end else if (l0_seen) begin
                if (ldn_cnt == LDN1) begin
                    ldn_evt <= 1'b1;
                    l0_seen <= 1'b0;
                    ldn_cnt <= '0;
                end else begin
                    ldn_cnt <= ldn_cnt + LDN_W'(1);
                end
            end else begin
                ldn_cnt <= '0;
            end
        end
    end

    always_ff @(posedge pld_clk) begin
        if (!app_rstn) begin
            state       <= S_HOLD;
            cnt         <= '0;
            pend        <= 1'b0;
            quiesce_req <= 1'b0;
            tx_rstn     <= 1'b0;
            rx_rstn     <= 1'b0;
            core_rstn   <= 1'b0;
            seq_busy    <= 1'b1;
            seq_done    <= 1'b0;
            qto_flag    <= 1'b0;
        end else begin
            seq_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req || pend) begin
                        state       <= S_QUIESCE;
                        cnt         <= '0;
                        pend        <= 1'b0;
                        quiesce_req <= 1'b1;
                        seq_busy    <= 1'b1;
                    end
                end
                S_QUIESCE: begin
                    if (bus.quiesce_ack || cnt == QTO1) begin
                        state   <= S_ASSERT;
                        cnt     <= '0;
                        tx_rstn <= 1'b0;
                        if (!bus.quiesce_ack) qto_flag <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_ASSERT: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == GAP1) rx_rstn <= 1'b0;
                    if (cnt == GAP2) begin
                        core_rstn   <= 1'b0;
                        quiesce_req <= 1'b0;
                        state       <= S_HOLD;
                        cnt         <= '0;
                    end
                end
                S_HOLD: begin
                    if (cnt == HOLD1) begin
                        state     <= S_RELEASE;
                        cnt       <= '0;
                        core_rstn <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_RELEASE: begin
                    // A request here is remembered and served right after the release completes.
                    if (req) pend <= 1'b1;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == GAP1) rx_rstn <= 1'b1;
                    if (cnt == GAP2) begin
                        tx_rstn  <= 1'b1;
                        state    <= S_IDLE;
                        cnt      <= '0;
                        seq_busy <= 1'b0;
                        seq_done <= 1'b1;
                    end
                end
                default: begin
                    state       <= S_HOLD;
                    cnt         <= '0;
                    quiesce_req <= 1'b0;
                    tx_rstn     <= 1'b0;
                    rx_rstn     <= 1'b0;
                    core_rstn   <= 1'b0;
                    seq_busy    <= 1'b1;
                end
            endcase
        end
    end

    assign bus.quiesce_req = quiesce_req;
    assign bus.tx_rstn     = tx_rstn;
    assign bus.rx_rstn     = rx_rstn;
    assign bus.core_rstn   = core_rstn;
    assign bus.seq_busy    = seq_busy;
    assign bus.seq_done    = seq_done;
    assign bus.qto_flag    = qto_flag;
endmodule

// File: tb/tb_pcie_app_rst_seq.sv
// tb/tb_pcie_app_rst_seq.sv - randomized self-checking bench for pcie_app_rst_seq against a timeline model
module tb_pcie_app_rst_seq;
    localparam int H   = 16;
    localparam int G   = 4;
    localparam int QTO = 1024;
    localparam int LDN = 8;

    logic pld_clk;
    logic app_rstn;
    pcie_app_rst_seq_if bus();

    pcie_app_rst_seq #(
        .HOLD_CYC(H), .GAP_CYC(G), .QTO_CYC(QTO), .LDN_DEB(LDN), .CNT_W(11)
    ) dut (
        .pld_clk (pld_clk),
        .app_rstn(app_rstn),
        .bus     (bus)
    );

    initial begin
        pld_clk = 1'b0;
        forever #5 pld_clk = ~pld_clk;
    end

    int vectors = 0;
    int miscompares = 0;

    // Model: a sequence is a timeline t counted from the first ASSERT cycle; reset lands at t=2G.
    typedef enum {M_IDLE, M_QUI, M_RST} mphase_t;
    mphase_t m_ph;
    int      m_t, m_q, m_cyc, m_last_l0;
    bit      m_pend, m_done, m_qto, m_armed, m_hotprev, m_ldn, m_hot;

    task automatic model_edge(input bit rstn, input logic [4:0] lt, input bit sw, input bit ack);
        bit req;
        m_cyc++;
        if (!rstn) begin
            m_ph = M_RST; m_t = 2 * G; m_pend = 0; m_done = 0; m_qto = 0;
            m_armed = 0; m_hotprev = 0; m_ldn = 0; m_hot = 0;
            return;
        end
        req    = sw | m_ldn | m_hot;
        m_done = 0;
        case (m_ph)
            M_IDLE: if (req || m_pend) begin m_ph = M_QUI; m_q = 0; m_pend = 0; end
            M_QUI: begin
                if (ack || m_q == QTO - 1) begin
                    if (!ack) m_qto = 1;
                    m_ph = M_RST; m_t = 0;
                end else m_q++;
            end
            default: begin
                if (req && m_t >= 2 * G + H) m_pend = 1;
                if (m_t == 4 * G + H - 1) begin m_ph = M_IDLE; m_done = 1; end
                else m_t++;
            end
        endcase
        if (lt == 5'h0F) begin m_armed = 1; m_last_l0 = m_cyc; m_ldn = 0; end
        else if (m_armed && (m_cyc - m_last_l0) == LDN) begin m_ldn = 1; m_armed = 0; end
        else m_ldn = 0;
        m_hot     = (lt == 5'h10) && !m_hotprev;
        m_hotprev = (lt == 5'h10);
    endtask

    // {quiesce_req, tx_rstn, rx_rstn, core_rstn, seq_busy, seq_done, qto_flag}
    function automatic logic [6:0] exp_vec();
        case (m_ph)
            M_IDLE:  return {1'b0, 3'b111, 1'b0, m_done, m_qto};
            M_QUI:   return {1'b1, 3'b111, 1'b1, 1'b0, m_qto};
            default: return {logic'(m_t < 2 * G), 1'b0,
                             logic'(!(m_t >= G && m_t < 3 * G + H)),
                             logic'(!(m_t >= 2 * G && m_t < 2 * G + H)),
                             1'b1, 1'b0, m_qto};
        endcase
    endfunction

    function automatic logic [6:0] obs();
        return {bus.quiesce_req, bus.tx_rstn, bus.rx_rstn, bus.core_rstn,
                bus.seq_busy, bus.seq_done, bus.qto_flag};
    endfunction

    task automatic tick(input bit rstn, input logic [4:0] lt, input bit sw, input bit ack);
        app_rstn        = rstn;
        bus.ltssm       = lt;
        bus.sw_rst_req  = sw;
        bus.quiesce_ack = ack;
        model_edge(rstn, lt, sw, ack);
        @(posedge pld_clk);
        @(negedge pld_clk);
        bus.sw_rst_req = 1'b0;
    endtask

    task automatic test_reset();
        int core_r = -1, rx_r = -1, tx_r = -1, dcnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick(0, 5'h07, 0, 0);
            vectors++;
            if (obs() !== exp_vec()) begin miscompares++; $display("FAIL reset_hold i=%0d got=%b exp=%b", i, obs(), exp_vec()); end
        end
        for (int i = 1; i <= H + 4 * G + 4; i++) begin
            tick(1, 5'h07, 0, 0);
            vectors++;
            if (obs() !== exp_vec()) begin miscompares++; $display("FAIL reset_release i=%0d got=%b exp=%b", i, obs(), exp_vec()); end
            if (core_r < 0 && bus.core_rstn === 1'b1) core_r = i;
            if (rx_r < 0 && bus.rx_rstn === 1'b1) rx_r = i;
            if (tx_r < 0 && bus.tx_rstn === 1'b1) tx_r = i;
            if (bus.seq_done === 1'b1) dcnt++;
        end
        vectors++;
        if (core_r != H || rx_r - core_r != G || tx_r - rx_r != G) begin
            miscompares++;
            $display("FAIL reset_order core=%0d rx=%0d tx=%0d exp core=%0d gap=%0d", core_r, rx_r, tx_r, H, G);
        end
        vectors++;
        if (dcnt != 1) begin miscompares++; $display("FAIL reset_done_pulses got=%0d exp=1", dcnt); end
    endtask

    task automatic test_sw_quiesce();
        int tx_f = -1, rx_f = -1, core_f = -1;
        tick(1, 5'h07, 1, 0);
        vectors++;
        if (obs() !== exp_vec()) begin miscompares++; $display("FAIL sw_start got=%b exp=%b", obs(), exp_vec()); end
        for (int i = 0; i < 10; i++) begin
            tick(1, 5'h07, 0, 0);
            vectors++;
            if (obs() !== exp_vec()) begin miscompares++; $display("FAIL sw_wait i=%0d got=%b exp=%b", i, obs(), exp_vec()); end
        end
        for (int i = 1; i <= 200; i++) begin
            tick(1, 5'h07, 0, 1);
            vectors++;
            if (obs() !== exp_vec()) begin miscompares++; $display("FAIL sw_seq i=%0d got=%b exp=%b", i, obs(), exp_vec()); end
            if (tx_f < 0 && bus.tx_rstn === 1'b0) tx_f = i;
            if (rx_f < 0 && bus.rx_rstn === 1'b0) rx_f = i;
            if (core_f < 0 && bus.core_rstn === 1'b0) core_f = i;
            if (m_ph == M_IDLE) break;
        end
        vectors++;
        if (tx_f != 1 || rx_f - tx_f != G || core_f - rx_f != G) begin
            miscompares++;
            $display("FAIL sw_assert_order tx=%0d rx=%0d core=%0d exp tx=1 gap=%0d", tx_f, rx_f, core_f, G);
        end
        vectors++;
        if (bus.qto_flag !== 1'b0) begin miscompares++; $display("FAIL sw_qto got=%b exp=0", bus.qto_flag); end
    endtask

    task automatic test_timeout();
        int qcnt = 0;
        tick(1, 5'h07, 1, 0);
        for (int k = 0; k < QTO + 50 && bus.tx_rstn === 1'b1; k++) begin
            vectors++;
            if (obs() !== exp_vec()) begin miscompares++; $display("FAIL qto_wait k=%0d got=%b exp=%b", k, obs(), exp_vec()); end
            if (bus.quiesce_req === 1'b1) qcnt++;
            tick(1, 5'h07, 0, 0);
        end
        vectors++;
        if (qcnt != QTO) begin miscompares++; $display("FAIL qto_length got=%0d exp=%0d", qcnt, QTO); end
        for (int i = 0; i < 200; i++) begin
            vectors++;
            if (obs() !== exp_vec()) begin miscompares++; $display("FAIL qto_seq i=%0d got=%b exp=%b", i, obs(), exp_vec()); end
            if (m_ph == M_IDLE) break;
            tick(1, 5'h07, 0, 0);
        end
        tick(1, 5'h07, 1, 0);
        for (int i = 0; i < 200; i++) begin
            tick(1, 5'h07, 0, 1);
            vectors++;
            if (obs() !== exp_vec()) begin miscompares++; $display("FAIL qto_sticky_seq i=%0d got=%b exp=%b", i, obs(), exp_vec()); end
            if (m_ph == M_IDLE) break;
        end
        vectors++;
        if (bus.qto_flag !== 1'b1) begin miscompares++; $display("FAIL qto_sticky got=%b exp=1", bus.qto_flag); end
    endtask

    task automatic test_link_events();
        for (int i = 0; i < 5; i++) tick(1, 5'h0F, 0, 0);
        for (int i = 0; i < LDN - 1; i++) tick(1, 5'h07, 0, 0);
        for (int i = 0; i < 4; i++) begin
            tick(1, 5'h0F, 0, 0);
            vectors++;
            if (obs() !== exp_vec()) begin miscompares++; $display("FAIL ldn_short i=%0d got=%b exp=%b", i, obs(), exp_vec()); end
        end
        vectors++;
        if (bus.seq_busy !== 1'b0) begin miscompares++; $display("FAIL ldn_short_busy got=%b exp=0", bus.seq_busy); end
        for (int i = 0; i < LDN; i++) tick(1, 5'h07, 0, 0);
        vectors++;
        if (bus.seq_busy !== 1'b0) begin miscompares++; $display("FAIL ldn_latency got=%b exp=0", bus.seq_busy); end
        tick(1, 5'h07, 0, 0);
        vectors++;
        if (bus.quiesce_req !== 1'b1) begin miscompares++; $display("FAIL ldn_start got=%b exp=1", bus.quiesce_req); end
        for (int i = 0; i < 200; i++) begin
            tick(1, 5'h07, 0, 1);
            vectors++;
            if (obs() !== exp_vec()) begin miscompares++; $display("FAIL ldn_seq i=%0d got=%b exp=%b", i, obs(), exp_vec()); end
            if (m_ph == M_IDLE) break;
        end
        tick(1, 5'h10, 0, 0);
        tick(1, 5'h10, 0, 0);
        vectors++;
        if (bus.quiesce_req !== 1'b1) begin miscompares++; $display("FAIL hot_start got=%b exp=1", bus.quiesce_req); end
        for (int i = 0; i < 200; i++) begin
            tick(1, 5'h10, 0, 1);
            vectors++;
            if (obs() !== exp_vec()) begin miscompares++; $display("FAIL hot_seq i=%0d got=%b exp=%b", i, obs(), exp_vec()); end
            if (m_ph == M_IDLE) break;
        end
    endtask

    task automatic test_back_to_back();
        bit sw;
        tick(1, 5'h07, 1, 0);
        for (int i = 0; i < 200; i++) begin
            sw = (m_ph == M_RST) && (m_t == 2 * G + 3 || m_t == 2 * G + H + 1);
            tick(1, 5'h07, sw, 1);
            vectors++;
            if (obs() !== exp_vec()) begin miscompares++; $display("FAIL b2b_seq i=%0d got=%b exp=%b", i, obs(), exp_vec()); end
            if (m_ph == M_IDLE) break;
        end
        vectors++;
        if (bus.seq_done !== 1'b1) begin miscompares++; $display("FAIL b2b_done got=%b exp=1", bus.seq_done); end
        tick(1, 5'h07, 0, 1);
        vectors++;
        if (bus.quiesce_req !== 1'b1 || bus.seq_done !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_requeue got qreq=%b done=%b exp qreq=1 done=0", bus.quiesce_req, bus.seq_done);
        end
        for (int i = 0; i < 200; i++) begin
            tick(1, 5'h07, 0, 1);
            vectors++;
            if (obs() !== exp_vec()) begin miscompares++; $display("FAIL b2b_second i=%0d got=%b exp=%b", i, obs(), exp_vec()); end
            if (m_ph == M_IDLE) break;
        end
        for (int i = 0; i < 3; i++) tick(1, 5'h07, 0, 0);
        vectors++;
        if (bus.seq_busy !== 1'b0) begin miscompares++; $display("FAIL b2b_hold_ignored got=%b exp=0", bus.seq_busy); end
    endtask

    task automatic test_reset_in_quiesce();
        tick(1, 5'h07, 1, 0);
        for (int i = 0; i < 5; i++) tick(1, 5'h07, 0, 0);
        tick(0, 5'h07, 0, 0);
        vectors++;
        if (obs() !== 7'b0000100) begin miscompares++; $display("FAIL rstq_abort got=%b exp=0000100", obs()); end
        for (int i = 0; i < 200; i++) begin
            tick(1, 5'h07, 0, 0);
            vectors++;
            if (obs() !== exp_vec()) begin miscompares++; $display("FAIL rstq_restart i=%0d got=%b exp=%b", i, obs(), exp_vec()); end
            if (m_ph == M_IDLE) break;
        end
        vectors++;
        if (bus.seq_done !== 1'b1) begin miscompares++; $display("FAIL rstq_done got=%b exp=1", bus.seq_done); end
    endtask

    task automatic test_random();
        logic [4:0] lt = 5'h07;
        int r;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 11) == 0) begin
                r = $urandom_range(0, 9);
                lt = (r < 5) ? 5'h0F : (r < 7) ? 5'h07 : (r < 9) ? 5'h10 : 5'($urandom);
            end
            tick($urandom_range(0, 599) != 0, lt, $urandom_range(0, 39) == 0, $urandom_range(0, 7) == 0);
            vectors++;
            if (obs() !== exp_vec()) begin miscompares++; $display("FAIL random i=%0d lt=%h got=%b exp=%b", i, lt, obs(), exp_vec()); end
        end
    endtask

    initial begin
        app_rstn        = 1'b0;
        bus.ltssm       = 5'h07;
        bus.sw_rst_req  = 1'b0;
        bus.quiesce_ack = 1'b0;
        m_cyc = 0; m_last_l0 = 0; m_q = 0; m_t = 2 * G; m_ph = M_RST;
        @(negedge pld_clk);
        test_reset();
        test_sw_quiesce();
        test_timeout();
        test_link_events();
        test_back_to_back();
        test_reset_in_quiesce();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
